// File: rtl/muldiv_unit_if.sv
// Operand/request and register-file write-back signals of the multiply/divide unit.
// The master issues requests and receives writes; the unit itself is the slave.
interface MulDivIf;
  logic        start;
  logic        op;
  logic [2:0]  destAddr;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic        write;
  logic [2:0]  wrAddr;
  logic [15:0] wrData;

  modport master (
    output start, op, destAddr, opA, opB,
    input  busy, done, divByZero, write, wrAddr, wrData
  );

  modport slave (
    input  start, op, destAddr, opA, opB,
    output busy, done, divByZero, write, wrAddr, wrData
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 16x16 unsigned multiplier / 16/16 restoring divider.
// Results go back to the register file in two write cycles: the low word to destAddr, then the high word to R0.
module muldiv_unit (
  input  logic   clk,
  input  logic   reset,
  MulDivIf.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    WR_LO,
    WR_HI
  } stateT;

  stateT       state;
  stateT       nextState;

  logic        opReg;
  logic [2:0]  destReg;
  logic [15:0] aReg;
  logic [15:0] bReg;
  logic [4:0]  count;

  // hiReg/loReg hold {partial product, multiplier} or {remainder, quotient}.
  logic [15:0] hiReg;
  logic [15:0] loReg;

  logic        lastIter;
  logic        divisorZero;
  logic [16:0] mulSum;
  logic [16:0] divShift;
  logic        divFits;
  logic [15:0] divDiff;
  logic [15:0] divRem;

  assign lastIter    = (count == 5'd15);
  assign divisorZero = (bReg == 16'd0);

  // Shift-add step: add the multiplicand when the current multiplier bit is set, then shift right.
  assign mulSum = {1'b0, hiReg} + (loReg[0] ? {1'b0, aReg} : 17'd0);

  // Restoring step: bring in the next dividend bit and subtract only if the divisor fits.
  assign divShift = {hiReg, loReg[15]};
  assign divFits  = (divShift >= {1'b0, bReg});
  assign divDiff  = divShift[15:0] - bReg;
  assign divRem   = divFits ? divDiff : divShift[15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A zero divisor spends a single DIV cycle to load the saturated result, then goes straight to write-back.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          nextState = bus.op ? DIV : MUL;
        end
      end
      MUL: begin
        if (lastIter) begin
          nextState = WR_LO;
        end
      end
      DIV: begin
        if (divisorZero || lastIter) begin
          nextState = WR_LO;
        end
      end
      WR_LO:   nextState = WR_HI;
      WR_HI:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opReg   <= 1'b0;
      destReg <= 3'd0;
      aReg    <= 16'd0;
      bReg    <= 16'd0;
      count   <= 5'd0;
      hiReg   <= 16'd0;
      loReg   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opReg   <= bus.op;
            destReg <= bus.destAddr;
            aReg    <= bus.opA;
            bReg    <= bus.opB;
            count   <= 5'd0;
            hiReg   <= 16'd0;
            loReg   <= bus.op ? bus.opA : bus.opB;
          end
        end
        MUL: begin
          hiReg <= mulSum[16:1];
          loReg <= {mulSum[0], loReg[15:1]};
          count <= count + 5'd1;
        end
        DIV: begin
          if (divisorZero) begin
            loReg <= 16'hFFFF;
            hiReg <= aReg;
          end else begin
            hiReg <= divRem;
            loReg <= {loReg[14:0], divFits};
            count <= count + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs depend only on the state and datapath registers, never on the request inputs.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.write     = 1'b0;
    bus.wrAddr    = 3'd0;
    bus.wrData    = 16'd0;
    bus.done      = 1'b0;
    bus.divByZero = 1'b0;
    case (state)
      WR_LO: begin
        bus.write  = 1'b1;
        bus.wrAddr = destReg;
        bus.wrData = loReg;
      end
      WR_HI: begin
        bus.write     = 1'b1;
        bus.wrAddr    = 3'd0;
        bus.wrData    = hiReg;
        bus.done      = 1'b1;
        bus.divByZero = opReg && divisorZero;
      end
      default: begin
      end
    endcase
  end

endmodule
